vproc_result_seq: RTL and testbench
===================================

// Module: vproc_result_seq
//
// PURPOSE
// In-order sequencer for scalar (xreg) results from several vector execution units.
// - Records, at dispatch, the instruction ID and the producing unit of every instruction
//   that returns an xreg result.
// - Forwards unit results strictly in dispatch order through one registered output.
// - The output feeds the xreg result input of the result interface block, so scalar
//   writebacks reach the host in program order.
//
// PARAMETERS
// XIF_ID_W        3     width of instruction IDs; order FIFO depth = 2**XIF_ID_W
// REQ_CNT         2     number of result-producing units (>=2)
// DONT_CARE_ZERO  1'b0  drive res_id_o/res_addr_o/res_data_o to 0 (else 'x) when res_valid_o=0
//
// PORTS
// clk_i           in   1                  clock
// async_rst_ni    in   1                  asynchronous reset, active-low
// sync_rst_ni     in   1                  synchronous reset, active-low (same effect as flush_i)
// flush_i         in   1                  discard all pending entries and the output register
// issue_valid_i   in   1                  dispatch of an xreg-result instruction
// issue_ready_o   out  1                  order FIFO not full
// issue_id_i      in   XIF_ID_W           ID of the dispatched instruction
// issue_src_i     in   $clog2(REQ_CNT)    unit that will produce its result
// req_valid_i     in   REQ_CNT            per-unit result valid
// req_ready_o     out  REQ_CNT            per-unit result accept (one-hot or zero)
// req_id_i        in   REQ_CNT*XIF_ID_W   per-unit result ID (unit k at [k*XIF_ID_W +: XIF_ID_W])
// req_addr_i      in   REQ_CNT*5          per-unit destination xreg
// req_data_i      in   REQ_CNT*32         per-unit result data
// res_valid_o     out  1                  result to result interface valid
// res_ready_i     in   1                  result interface accepts
// res_id_o        out  XIF_ID_W           result ID
// res_addr_o      out  5                  result xreg address
// res_data_o      out  32                 result data
// err_o           out  1                  sticky: unit presented a wrong ID at the FIFO head
//
// BEHAVIOUR
// - Reset (async or sync):
//   - FIFO empty; count=0; rd/wr pointers=0.
//   - res_valid_o=0, err_o=0, issue_ready_o=1, req_ready_o=0.
//   - Data/ID/address registers are not reset.
// - Order FIFO: depth D=2**XIF_ID_W; entries {id, src}; count width XIF_ID_W+1.
//   - Pointers wrap D-1 -> 0.
//   - issue_ready_o = (count != D). Push on issue_valid_i & issue_ready_o.
//   - No bypass: a pushed entry reaches the head the next cycle at the earliest.
// - Selection: head_src = FIFO head src.
//   - slot_free = ~res_valid_o | res_ready_i.
//   - take = (count!=0) & req_valid_i[head_src] & (req_id_i[head_src]==head id) & slot_free & ~flush.
//   - req_ready_o[head_src] = take; all other bits 0. Combinational in req_valid_i and res_ready_i.
//   - On take: pop the FIFO and load the output register with {head id, req_addr, req_data}.
//     - res_valid_o=1 next cycle. Latency 1 cycle; throughput 1 result/cycle.
//   - Output holds: if res_valid_o & ~res_ready_i, the output fields stay stable.
//   - If res_ready_i and no take, res_valid_o clears.
// - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Allowed at count=D only if issue_ready_o=1, i.e. not at full; push never depends on pop.
// - Non-head unit valid: ignored (ready=0). That unit waits; there is no reordering storage.
// - ID mismatch: req_valid_i[head_src] with a wrong ID sets err_o (sticky until reset).
//   The request is not accepted.
// - flush_i or ~sync_rst_ni:
//   - Highest priority. Next cycle: FIFO empty, res_valid_o=0.
//   - Same-cycle issue is dropped; req_ready_o=0 in the flush cycle.
//   - err_o clears only on ~sync_rst_ni or async reset, not on flush_i.
// - An ID appears at most once in the FIFO (host guarantees it). This is not checked in RTL.
//
// TESTING
// 1. Issue IDs 1(src0), 2(src1); unit1 valid id2 first, then unit0 valid id1
//    -> unit1 stalls; outputs id1 then id2, one cycle after each take.
// 2. Fill 8 entries -> issue_ready_o=0. Next cycle take + res_ready_i=1 -> issue_ready_o=1.
//    Then 8 further pushes/pops wrap pointers with order preserved.
// 3. res_ready_i=0 for 3 cycles with a result pending -> res_*_o stable, req_ready_o=0.
//    Back-to-back takes resume at 1/cycle once res_ready_i=1.
// 4. Head {id3,src0}, unit0 presents id5 -> req_ready_o=0, err_o=1 next cycle and stays high.
// 5. 4 pending + res_valid_o=1, assert flush_i with issue_valid_i=1
//    -> next cycle count=0, res_valid_o=0, issued ID dropped.
// 6. async_rst_ni low mid-stream -> res_valid_o=0 and issue_ready_o=1 immediately.
//    First result after release is the first newly issued ID.

Source files
------------

// File: rtl/vproc_result_seq_if.sv
// Dispatch, per-unit result and in-order result handshakes of the xreg result sequencer.
// The slave modport is the sequencer; the master modport is the surrounding pipeline.
interface vproc_result_seq_if #(
  parameter int unsigned XIF_ID_W = 3,
  parameter int unsigned REQ_CNT  = 2
);
  localparam int unsigned SRC_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  logic                         issue_valid_i;
  logic                         issue_ready_o;
  logic [XIF_ID_W-1:0]          issue_id_i;
  logic [SRC_W-1:0]             issue_src_i;
  logic [REQ_CNT-1:0]           req_valid_i;
  logic [REQ_CNT-1:0]           req_ready_o;
  logic [REQ_CNT*XIF_ID_W-1:0]  req_id_i;
  logic [REQ_CNT*5-1:0]         req_addr_i;
  logic [REQ_CNT*32-1:0]        req_data_i;
  logic                         res_valid_o;
  logic                         res_ready_i;
  logic [XIF_ID_W-1:0]          res_id_o;
  logic [4:0]                   res_addr_o;
  logic [31:0]                  res_data_o;

  modport slave (
    input  issue_valid_i, issue_id_i, issue_src_i,
    input  req_valid_i, req_id_i, req_addr_i, req_data_i,
    input  res_ready_i,
    output issue_ready_o, req_ready_o,
    output res_valid_o, res_id_o, res_addr_o, res_data_o
  );

  modport master (
    output issue_valid_i, issue_id_i, issue_src_i,
    output req_valid_i, req_id_i, req_addr_i, req_data_i,
    output res_ready_i,
    input  issue_ready_o, req_ready_o,
    input  res_valid_o, res_id_o, res_addr_o, res_data_o
  );
endinterface

// File: rtl/vproc_result_seq.sv
// In-order sequencer for xreg results: an order FIFO of {id, src} recorded at dispatch
// selects which unit may hand over its result next, through one registered output.
module vproc_result_seq #(
  parameter int unsigned XIF_ID_W       = 3,
  parameter int unsigned REQ_CNT        = 2,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic              clk_i,
  input  logic              async_rst_ni,
  input  logic              sync_rst_ni,
  input  logic              flush_i,
  vproc_result_seq_if.slave bus,
  output logic              err_o
);
  localparam int unsigned SRC_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int unsigned DEPTH = 2 ** XIF_ID_W;
  localparam logic [XIF_ID_W:0] FULL = (XIF_ID_W+1)'(DEPTH);

  logic [XIF_ID_W-1:0] fifo_id  [DEPTH];
  logic [SRC_W-1:0]    fifo_src [DEPTH];
  logic [XIF_ID_W-1:0] rd_ptr, wr_ptr;
  logic [XIF_ID_W:0]   count;

  logic                clear, push, take, mismatch, slot_free, nonempty;
  logic [XIF_ID_W-1:0] head_id;
  logic [SRC_W-1:0]    head_src;
  logic                head_vld;
  logic [XIF_ID_W-1:0] head_req_id;
  logic [4:0]          head_addr;
  logic [31:0]         head_data;

  logic                vld_p1;
  logic [XIF_ID_W-1:0] res_id_p1;
  logic [4:0]          res_addr_p1;
  logic [31:0]         res_data_p1;
  logic                err_q;

  assign clear     = flush_i | ~sync_rst_ni;
  assign nonempty  = (count != '0);
  assign head_id   = fifo_id[rd_ptr];
  assign head_src  = fifo_src[rd_ptr];
  assign slot_free = ~vld_p1 | bus.res_ready_i;

  assign bus.issue_ready_o = (count != FULL);
  assign push = bus.issue_valid_i & bus.issue_ready_o & ~clear;

  // Only the unit owning the FIFO head is looked at; the others simply wait.
  always_comb begin
    head_vld    = 1'b0;
    head_req_id = '0;
    head_addr   = '0;
    head_data   = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (head_src == SRC_W'(k)) begin
        head_vld    = bus.req_valid_i[k];
        head_req_id = bus.req_id_i[k*XIF_ID_W +: XIF_ID_W];
        head_addr   = bus.req_addr_i[k*5 +: 5];
        head_data   = bus.req_data_i[k*32 +: 32];
      end
    end
  end

  assign take     = nonempty & head_vld & (head_req_id == head_id) & slot_free & ~clear;
  assign mismatch = nonempty & head_vld & (head_req_id != head_id);

  always_comb begin
    bus.req_ready_o = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      bus.req_ready_o[k] = take & (head_src == SRC_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        vld_p1 <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (take) rd_ptr <= rd_ptr + 1'b1;
        if (push && !take) count <= count + 1'b1;
        else if (!push && take) count <= count - 1'b1;
        if (take) vld_p1 <= 1'b1;
        else if (bus.res_ready_i) vld_p1 <= 1'b0;
      end
      // flush_i deliberately leaves the error flag alone
      if (!sync_rst_ni) err_q <= 1'b0;
      else if (mismatch) err_q <= 1'b1;
    end
  end

  // Stage p1: FIFO storage and output register, data only
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id[wr_ptr]  <= bus.issue_id_i;
      fifo_src[wr_ptr] <= bus.issue_src_i;
    end
    if (take) begin
      res_id_p1   <= head_id;
      res_addr_p1 <= head_addr;
      res_data_p1 <= head_data;
    end
  end

  assign bus.res_valid_o = vld_p1;
  assign bus.res_id_o    = vld_p1 ? res_id_p1   : (DONT_CARE_ZERO ? '0 : 'x);
  assign bus.res_addr_o  = vld_p1 ? res_addr_p1 : (DONT_CARE_ZERO ? '0 : 'x);
  assign bus.res_data_o  = vld_p1 ? res_data_p1 : (DONT_CARE_ZERO ? '0 : 'x);
  assign err_o = err_q;

endmodule

// File: tb/tb_vproc_result_seq.sv
// Directed bench for vproc_result_seq: ordering, full FIFO and wrap, back-pressure,
// ID mismatch, flush and asynchronous reset, each with hand-computed expectations.
module tb_vproc_result_seq;
  localparam int unsigned IDW = 3;
  localparam int unsigned RC  = 2;

  logic clk = 1'b0;
  logic arst_n, srst_n, flush, err;
  int   nvec = 0;
  int   nmis = 0;

  vproc_result_seq_if #(.XIF_ID_W(IDW), .REQ_CNT(RC)) bus();

  vproc_result_seq #(.XIF_ID_W(IDW), .REQ_CNT(RC), .DONT_CARE_ZERO(1'b0)) dut (
    .clk_i        (clk),
    .async_rst_ni (arst_n),
    .sync_rst_ni  (srst_n),
    .flush_i      (flush),
    .bus          (bus),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic v, input logic [2:0] id,
                          input logic [4:0] a, input logic [31:0] d);
    bus.req_valid_i[k]          = v;
    bus.req_id_i[k*IDW +: IDW]  = id;
    bus.req_addr_i[k*5 +: 5]    = a;
    bus.req_data_i[k*32 +: 32]  = d;
  endtask

  task automatic issue(input logic [2:0] id, input logic src);
    bus.issue_valid_i = 1'b1;
    bus.issue_id_i    = id;
    bus.issue_src_i   = src;
    tick();
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [2:0] id, input logic [4:0] a,
                         input logic [31:0] d);
    chk({tag, "_vld"},  bus.res_valid_o, 1'b1);
    chk({tag, "_id"},   bus.res_id_o, id);
    chk({tag, "_addr"}, bus.res_addr_o, a);
    chk({tag, "_data"}, bus.res_data_o, d);
  endtask

  initial begin
    arst_n = 1'b0; srst_n = 1'b1; flush = 1'b0;
    bus.issue_valid_i = 1'b0; bus.issue_id_i = '0; bus.issue_src_i = '0;
    bus.req_valid_i = '0; bus.req_id_i = '0; bus.req_addr_i = '0; bus.req_data_i = '0;
    bus.res_ready_i = 1'b0;
    tick(); tick();
    chk("rst_vld", bus.res_valid_o, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_irdy", bus.issue_ready_o, 1'b1);
    chk("rst_rrdy", bus.req_ready_o, 2'b00);
    arst_n = 1'b1;
    tick();

    // 1: unit1 ready first must wait for unit0
    issue(3'd1, 1'b0);
    issue(3'd2, 1'b1);
    set_unit(1, 1'b1, 3'd2, 5'd2, 32'hA2);
    bus.res_ready_i = 1'b1;
    #1 chk("t1_stall_rdy", bus.req_ready_o, 2'b00);
    tick();
    chk("t1_stall_vld", bus.res_valid_o, 1'b0);
    set_unit(0, 1'b1, 3'd1, 5'd1, 32'hA1);
    #1 chk("t1_take0_rdy", bus.req_ready_o, 2'b01);
    tick();
    chk_res("t1_res1", 3'd1, 5'd1, 32'hA1);
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    #1 chk("t1_take1_rdy", bus.req_ready_o, 2'b10);
    tick();
    chk_res("t1_res2", 3'd2, 5'd2, 32'hA2);
    set_unit(1, 1'b0, 3'd0, 5'd0, 32'h0);
    tick();
    chk("t1_drain_vld", bus.res_valid_o, 1'b0);

    // 2: fill, then pop/push together across the pointer wrap
    for (int i = 0; i < 8; i++) issue(3'(i), 1'b0);
    #1 chk("t2_full_irdy", bus.issue_ready_o, 1'b0);
    set_unit(0, 1'b1, 3'd0, 5'd3, 32'h100);
    #1 chk("t2_full_rrdy", bus.req_ready_o, 2'b01);
    tick();
    chk("t2_irdy_after_pop", bus.issue_ready_o, 1'b1);
    chk_res("t2_res0", 3'd0, 5'd3, 32'h100);
    for (int i = 1; i <= 8; i++) begin
      set_unit(0, 1'b1, 3'(i), 5'd3, 32'h100 + 32'(i));
      bus.issue_valid_i = 1'b1;
      bus.issue_id_i    = 3'(i - 1);
      bus.issue_src_i   = 1'b0;
      #1 chk("t2_wrap_rrdy", bus.req_ready_o, 2'b01);
      chk("t2_wrap_irdy", bus.issue_ready_o, 1'b1);
      tick();
      chk_res("t2_wrap_res", 3'(i), 5'd3, 32'h100 + 32'(i));
    end
    bus.issue_valid_i = 1'b0;
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_vld", bus.res_valid_o, 1'b0);
    chk("t2_flush_irdy", bus.issue_ready_o, 1'b1);

    // 3: output held under back-pressure
    bus.res_ready_i = 1'b0;
    issue(3'd4, 1'b1);
    issue(3'd5, 1'b1);
    issue(3'd6, 1'b1);
    set_unit(1, 1'b1, 3'd4, 5'd4, 32'hD4);
    #1 chk("t3_free_rrdy", bus.req_ready_o, 2'b10);
    tick();
    chk_res("t3_res4", 3'd4, 5'd4, 32'hD4);
    set_unit(1, 1'b1, 3'd5, 5'd5, 32'hD5);
    for (int c = 0; c < 3; c++) begin
      #1 chk("t3_hold_rrdy", bus.req_ready_o, 2'b00);
      tick();
      chk_res("t3_hold_res", 3'd4, 5'd4, 32'hD4);
    end
    bus.res_ready_i = 1'b1;
    #1 chk("t3_resume_rrdy", bus.req_ready_o, 2'b10);
    tick();
    chk_res("t3_res5", 3'd5, 5'd5, 32'hD5);
    set_unit(1, 1'b1, 3'd6, 5'd6, 32'hD6);
    tick();
    chk_res("t3_res6", 3'd6, 5'd6, 32'hD6);
    set_unit(1, 1'b0, 3'd0, 5'd0, 32'h0);
    tick();
    chk("t3_drain_vld", bus.res_valid_o, 1'b0);

    // 4: wrong ID at the head is refused and latched as an error
    issue(3'd3, 1'b0);
    set_unit(0, 1'b1, 3'd5, 5'd5, 32'hE5);
    #1 chk("t4_bad_rrdy", bus.req_ready_o, 2'b00);
    tick();
    chk("t4_err_set", err, 1'b1);
    chk("t4_no_res", bus.res_valid_o, 1'b0);
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    tick();
    chk("t4_err_sticky", err, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_err_after_flush", err, 1'b1);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    chk("t4_err_srst", err, 1'b0);

    // 5: flush with pending entries, a valid result and a same-cycle issue
    bus.res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) issue(3'(i), 1'b0);
    set_unit(0, 1'b1, 3'd0, 5'd1, 32'hF0);
    tick();
    chk_res("t5_res0", 3'd0, 5'd1, 32'hF0);
    flush = 1'b1;
    bus.issue_valid_i = 1'b1; bus.issue_id_i = 3'd7; bus.issue_src_i = 1'b0;
    set_unit(0, 1'b1, 3'd1, 5'd1, 32'hF1);
    bus.res_ready_i = 1'b1;
    #1 chk("t5_flush_rrdy", bus.req_ready_o, 2'b00);
    tick();
    flush = 1'b0;
    bus.issue_valid_i = 1'b0;
    chk("t5_flush_vld", bus.res_valid_o, 1'b0);
    chk("t5_flush_irdy", bus.issue_ready_o, 1'b1);
    #1 chk("t5_empty_rrdy", bus.req_ready_o, 2'b00);
    set_unit(0, 1'b1, 3'd6, 5'd6, 32'hF6);
    issue(3'd6, 1'b0);
    #1 chk("t5_new_head_rrdy", bus.req_ready_o, 2'b01);
    chk("t5_no_err", err, 1'b0);
    tick();
    chk_res("t5_res6", 3'd6, 5'd6, 32'hF6);
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    tick();

    // 6: asynchronous reset in the middle of traffic
    bus.res_ready_i = 1'b0;
    issue(3'd2, 1'b0);
    issue(3'd3, 1'b0);
    set_unit(0, 1'b1, 3'd2, 5'd2, 32'h22);
    tick();
    chk("t6_pre_vld", bus.res_valid_o, 1'b1);
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    #1 arst_n = 1'b0;
    #1 chk("t6_arst_vld", bus.res_valid_o, 1'b0);
    chk("t6_arst_irdy", bus.issue_ready_o, 1'b1);
    chk("t6_arst_rrdy", bus.req_ready_o, 2'b00);
    tick(); tick();
    arst_n = 1'b1;
    bus.res_ready_i = 1'b1;
    set_unit(0, 1'b1, 3'd5, 5'd5, 32'h55);
    issue(3'd5, 1'b0);
    #1 chk("t6_first_rrdy", bus.req_ready_o, 2'b01);
    tick();
    chk_res("t6_res5", 3'd5, 5'd5, 32'h55);
    set_unit(0, 1'b0, 3'd0, 5'd0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
